// File: rtl/alu_frame_ctrl_if.sv
// alu_frame_ctrl_if: RX/TX FIFO and ALU signal bundle for the frame controller
interface alu_frame_ctrl_if #(
    parameter int BYTE_W     = 8,
    parameter int OPND_BYTES = 2,
    parameter int OP_W       = 6
);
    logic [BYTE_W-1:0]            rx_data;
    logic                         rx_empty;
    logic                         rd;
    logic                         tx_full;
    logic                         wr;
    logic [BYTE_W-1:0]            tx_data;
    logic [BYTE_W*OPND_BYTES-1:0] op_a;
    logic [BYTE_W*OPND_BYTES-1:0] op_b;
    logic [OP_W-1:0]              op_code;
    logic [BYTE_W*OPND_BYTES-1:0] alu_result;
    logic                         alu_zero;
    logic                         alu_carry;
    logic                         alu_ovf;

    modport master (
        input  rx_data, rx_empty, tx_full, alu_result, alu_zero, alu_carry, alu_ovf,
        output rd, wr, tx_data, op_a, op_b, op_code
    );

    modport slave (
        output rx_data, rx_empty, tx_full, alu_result, alu_zero, alu_carry, alu_ovf,
        input  rd, wr, tx_data, op_a, op_b, op_code
    );
endinterface

// File: rtl/alu_frame_ctrl.sv
// alu_frame_ctrl: frames UART bytes into ALU operands/opcode and returns result plus status
module alu_frame_ctrl #(
    parameter int BYTE_W      = 8,
    parameter int OPND_BYTES  = 2,
    parameter int OP_W        = 6,
    parameter int TIMEOUT_CYC = 50000,
    parameter int STATUS_EN   = 1
) (
    input  logic             clk,
    input  logic             reset,
    alu_frame_ctrl_if.master bus,
    output logic             busy,
    output logic             frame_done,
    output logic             err_timeout
);
    localparam int RW = BYTE_W * OPND_BYTES;
    localparam int CW = OPND_BYTES > 1 ? $clog2(OPND_BYTES) : 1;
    localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC + 1) : 1;

    typedef enum logic [2:0] {RX_A, RX_B, RX_OP, EXEC, TX_RES, TX_STAT} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [TW-1:0] timer;
    logic [RW-1:0] result;
    logic [2:0]    flags;
    logic          rx_st;
    logic          last;
    logic          tmo;

    // Strobes, TX byte mux and abort decision; rd is gated by reset so no pop leaks while held
    always_comb begin
        rx_st       = state == RX_A || state == RX_B || state == RX_OP;
        last        = cnt == CW'(OPND_BYTES - 1);
        busy        = !(state == RX_A && cnt == '0);
        bus.rd      = reset && rx_st && !bus.rx_empty;
        bus.wr      = (state == TX_RES || state == TX_STAT) && !bus.tx_full;
        bus.tx_data = state == TX_RES  ? result[int'(cnt)*BYTE_W +: BYTE_W] :
                      state == TX_STAT ? BYTE_W'({err_timeout, flags}) : '0;
        frame_done  = bus.wr && (state == TX_STAT || (state == TX_RES && last && STATUS_EN == 0));
        tmo         = TIMEOUT_CYC != 0 && rx_st && busy && !bus.rd && timer == TW'(TIMEOUT_CYC - 1);
    end

    // Frame FSM: collect operands and opcode, execute once, stream result and status out
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= RX_A;
            cnt         <= '0;
            timer       <= '0;
            result      <= '0;
            flags       <= '0;
            err_timeout <= 1'b0;
            bus.op_a    <= '0;
            bus.op_b    <= '0;
            bus.op_code <= '0;
        end else if (tmo) begin
            state       <= RX_A;
            cnt         <= '0;
            timer       <= '0;
            err_timeout <= 1'b1;
        end else begin
            timer <= bus.rd || !busy || !rx_st ? '0 : timer + 1'b1;
            case (state)
                RX_A: if (bus.rd) begin
                    bus.op_a[int'(cnt)*BYTE_W +: BYTE_W] <= bus.rx_data;
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) state <= RX_B;
                end
                RX_B: if (bus.rd) begin
                    bus.op_b[int'(cnt)*BYTE_W +: BYTE_W] <= bus.rx_data;
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) state <= RX_OP;
                end
                RX_OP: if (bus.rd) begin
                    bus.op_code <= bus.rx_data[OP_W-1:0];
                    state       <= EXEC;
                end
                EXEC: begin
                    result <= bus.alu_result;
                    flags  <= {bus.alu_ovf, bus.alu_carry, bus.alu_zero};
                    cnt    <= '0;
                    state  <= TX_RES;
                end
                TX_RES: if (bus.wr) begin
                    cnt <= last ? '0 : cnt + 1'b1;
                    if (last) state <= STATUS_EN != 0 ? TX_STAT : RX_A;
                end
                TX_STAT: if (bus.wr) begin
                    err_timeout <= 1'b0;
                    state       <= RX_A;
                end
                default: state <= RX_A;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_frame_ctrl.sv
// tb_alu_frame_ctrl: directed and randomized frames against a byte-stream reference model
module tb_alu_frame_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy, frame_done, err_timeout;

    int n_cmp = 0, n_err = 0, n_done = 0, cyc = 0, last_rd = 0, first_wr = -1, lat = 0;
    logic s_rd, s_wr, s_busy;
    logic [7:0] s_td;
    logic hold = 1'b0, rand_bp = 1'b0, rand_gap = 1'b0;
    int hold_n = 0;
    logic err_exp = 1'b0;
    logic [7:0] rxq[$], txq[$], expq[$];

    alu_frame_ctrl_if #(.BYTE_W(8), .OPND_BYTES(2), .OP_W(6)) bus();

    alu_frame_ctrl #(.BYTE_W(8), .OPND_BYTES(2), .OP_W(6), .TIMEOUT_CYC(20), .STATUS_EN(1)) dut (
        .clk(clk), .reset(reset), .bus(bus.master),
        .busy(busy), .frame_done(frame_done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // ALU behaviour: 0x20 add, 0x21 sub, 0x22 and, 0x23 xor, otherwise pass A; returns {ovf,carry,zero,result}
    function automatic logic [18:0] alu_fn(input logic [15:0] a, b, input logic [5:0] op);
        int si;
        logic [15:0] r;
        logic c, v;
        si = 0; c = 1'b0; v = 1'b0; r = a;
        if (op == 6'h20) begin
            r = a + b; c = (int'(a) + int'(b)) > 65535;
            si = int'($signed(a)) + int'($signed(b)); v = si > 32767 || si < -32768;
        end else if (op == 6'h21) begin
            r = a - b; c = a < b;
            si = int'($signed(a)) - int'($signed(b)); v = si > 32767 || si < -32768;
        end else if (op == 6'h22) r = a & b;
        else if (op == 6'h23) r = a ^ b;
        return {v, c, r == 16'h0, r};
    endfunction

    always_comb {bus.alu_ovf, bus.alu_carry, bus.alu_zero, bus.alu_result} = alu_fn(bus.op_a, bus.op_b, bus.op_code);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic upd();
        bus.rx_empty = hold || rxq.size() == 0;
        bus.rx_data  = rxq.size() != 0 ? rxq[0] : 8'h00;
    endtask

    task automatic cycle();
        @(negedge clk);
        s_rd = bus.rd; s_wr = bus.wr; s_td = bus.tx_data; s_busy = busy;
        if (frame_done) n_done++;
        if (s_rd) last_rd = cyc;
        if (s_wr && first_wr < 0) begin first_wr = cyc; lat = cyc - last_rd; end
        @(posedge clk);
        #1;
        cyc++;
        if (s_rd) void'(rxq.pop_front());
        if (s_wr) txq.push_back(s_td);
        if (rand_bp) bus.tx_full = $urandom_range(0, 2) == 0;
        if (rand_gap) begin
            hold   = hold_n < 4 && $urandom_range(0, 3) == 0;
            hold_n = hold ? hold_n + 1 : 0;
        end
        upd();
    endtask

    task automatic frame(input logic [15:0] a, b, input logic [7:0] opb);
        logic [18:0] f;
        f = alu_fn(a, b, opb[5:0]);
        expq.push_back(f[7:0]);
        expq.push_back(f[15:8]);
        expq.push_back({4'b0, err_exp, f[18:16]});
        err_exp = 1'b0;
        rxq.push_back(a[7:0]); rxq.push_back(a[15:8]);
        rxq.push_back(b[7:0]); rxq.push_back(b[15:8]);
        rxq.push_back(opb);
        upd();
    endtask

    task automatic drain_rx(input string tag);
        int k;
        k = 0;
        while (rxq.size() != 0 && k < 100) begin cycle(); k++; end
        check({tag, "_drain"}, rxq.size(), 0);
    endtask

    task automatic run_frame(input string tag);
        int d0, k;
        d0 = n_done; k = 0;
        while (n_done == d0 && k < 400) begin cycle(); k++; end
        check({tag, "_done"}, n_done - d0, 1);
        check({tag, "_txn"}, txq.size(), expq.size());
        for (int i = 0; i < expq.size() && i < txq.size(); i++)
            check($sformatf("%s_tx%0d", tag, i), txq[i], expq[i]);
        txq.delete();
        expq.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        logic [7:0] ro;
        int k;
        bus.tx_full = 1'b0;
        rxq.push_back(8'hAA);
        upd();
        #1;
        check("rst_rd", bus.rd, 0);
        check("rst_wr", bus.wr, 0);
        check("rst_txd", bus.tx_data, 0);
        check("rst_opa", bus.op_a, 0);
        check("rst_opb", bus.op_b, 0);
        check("rst_opc", bus.op_code, 0);
        check("rst_busy", busy, 0);
        check("rst_done", frame_done, 0);
        check("rst_err", err_timeout, 0);
        rxq.delete();
        upd();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;

        first_wr = -1;
        frame(16'h1234, 16'h0101, 8'h20);
        drain_rx("basic");
        check("basic_opa", bus.op_a, 16'h1234);
        check("basic_opb", bus.op_b, 16'h0101);
        check("basic_opc", bus.op_code, 8'h20);
        run_frame("basic");
        check("basic_lat", lat, 2);
        k = n_done;
        repeat (3) cycle();
        check("basic_once", n_done - k, 0);

        frame(16'hFFFF, 16'h0001, 8'h20);
        run_frame("flags");

        bus.tx_full = 1'b1;
        frame(16'hABCD, 16'h1111, 8'h21);
        drain_rx("bp");
        cycle();
        for (int i = 0; i < 10; i++) begin
            cycle();
            check($sformatf("bp_wr%0d", i), s_wr, 0);
            check($sformatf("bp_td%0d", i), s_td, expq[0]);
        end
        bus.tx_full = 1'b0;
        run_frame("bp");

        rxq.push_back(8'h11); rxq.push_back(8'h22); rxq.push_back(8'h33);
        upd();
        drain_rx("tmo");
        repeat (20) cycle();
        check("tmo_busy_before", s_busy, 1);
        check("tmo_busy", busy, 0);
        check("tmo_err", err_timeout, 1);
        check("tmo_nowr", txq.size(), 0);
        err_exp = 1'b1;
        frame(16'h0005, 16'h0003, 8'h21);
        run_frame("tmo_next");
        check("tmo_err_clr", err_timeout, 0);

        rxq.push_back(8'h10); rxq.push_back(8'h00); rxq.push_back(8'h20);
        upd();
        drain_rx("race");
        repeat (19) cycle();
        check("race_busy", busy, 1);
        expq.push_back(8'h00); expq.push_back(8'h00); expq.push_back(8'h01);
        rxq.push_back(8'h00); rxq.push_back(8'h22);
        upd();
        run_frame("race");
        check("race_err", err_timeout, 0);

        frame(16'h00F0, 16'h000F, 8'h23);
        k = 0;
        while (txq.size() == 0 && k < 100) begin cycle(); k++; end
        check("mid_first", txq.size(), 1);
        expq.delete();
        reset = 1'b0;
        frame(16'h7FFF, 16'h0001, 8'h20);
        #1;
        check("mid_rd", bus.rd, 0);
        check("mid_wr", bus.wr, 0);
        check("mid_txd", bus.tx_data, 0);
        check("mid_opa", bus.op_a, 0);
        check("mid_busy", busy, 0);
        check("mid_err", err_timeout, 0);
        repeat (3) cycle();
        check("mid_nowr", txq.size(), 1);
        txq.delete();
        reset = 1'b1;
        run_frame("mid_after");
        check("mid_after_opa", bus.op_a, 16'h7FFF);

        rand_bp = 1'b1;
        rand_gap = 1'b1;
        for (int n = 0; n < 20; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            ro = {2'($urandom), 6'h20 + 6'($urandom_range(0, 4))};
            frame(ra, rb, ro);
            run_frame($sformatf("rnd%0d", n));
            check($sformatf("rnd%0d_opc", n), bus.op_code, ro[5:0]);
        end
        rand_bp = 1'b0;
        rand_gap = 1'b0;
        hold = 1'b0;
        bus.tx_full = 1'b0;
        upd();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
